// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: op encodings, default latencies, controller state type.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdu_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MUL_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF = 10;

    // Ops that occupy the MDU for a full multi-cycle latency.
    function automatic logic is_start_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_issue_op(input logic [2:0] op);
        return is_start_op(op) || (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline <-> MDU controller handshake bundle.
interface mdu_ctrl_if;
    logic       req;
    logic       e_valid;
    logic [2:0] e_op;
    logic       d_hilo_use;
    logic       mdu_busy;
    logic       mdu_start;
    logic [2:0] mdu_op;
    logic       stall_d;
    logic       ctrl_busy;
    logic       mismatch;

    modport master (
        output req, e_valid, e_op, d_hilo_use, mdu_busy,
        input  mdu_start, mdu_op, stall_d, ctrl_busy, mismatch
    );

    modport slave (
        input  req, e_valid, e_op, d_hilo_use, mdu_busy,
        output mdu_start, mdu_op, stall_d, ctrl_busy, mismatch
    );
endinterface

// File: rtl/mdu_ctrl_cnt.sv
// Loadable down-counter with hold; term flags the last counted cycle (cnt==1).
module mdu_ctrl_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         hold,
    input  logic [W-1:0] load_val,
    output logic         term
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (!hold && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign term = (cnt == W'(1));
endmodule

// File: rtl/mdu_ctrl.sv
// MDU issue/stall controller: tracks the multi-cycle MDU op and flags busy disagreement.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input logic       clk,
    input logic       reset,
    mdu_ctrl_if.slave bus
);
    mdu_state_t state, state_nxt;
    logic       issue, start_go, term, cnt_hold, mismatch_q;
    logic [CNT_W-1:0] lat_val;

    assign issue    = (state == ST_IDLE) && bus.e_valid && !bus.req && is_issue_op(bus.e_op);
    assign start_go = issue && is_start_op(bus.e_op);
    assign lat_val  = is_mul_op(bus.e_op) ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
    // Counter only runs in RUN; req freezes it together with the MDU datapath.
    assign cnt_hold = bus.req || (state != ST_RUN);

    mdu_ctrl_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (start_go),
        .hold     (cnt_hold),
        .load_val (lat_val),
        .term     (term)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_go) state_nxt = ST_RUN;
            ST_RUN:  if (!bus.req && term) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.mdu_start = 1'b0;
        bus.mdu_op    = OP_NONE;
        bus.stall_d   = 1'b0;
        if (!reset) begin
            bus.mdu_start = start_go;
            if (issue)
                bus.mdu_op = bus.e_op;
            bus.stall_d = bus.d_hilo_use && ((state == ST_RUN) || start_go);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            mismatch_q <= 1'b0;
        else if (bus.mdu_busy != (state == ST_RUN))
            mismatch_q <= 1'b1;
    end

    assign bus.ctrl_busy = (state == ST_RUN);
    assign bus.mismatch  = mismatch_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: vector table through a scoreboard queue, plus a busy-mismatch sequence.
module tb_mdu_ctrl;
    logic clk;
    logic reset;
    mdu_ctrl_if bus ();

    mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model MDU: busy the cycle after start for the op latency, frozen by req.
    int unsigned mcnt;
    logic busy_d;
    logic late;
    always @(posedge clk) begin
        if (reset) begin
            mcnt   <= 0;
            busy_d <= 1'b0;
        end else begin
            busy_d <= (mcnt != 0);
            if (bus.mdu_start)
                mcnt <= (bus.mdu_op == 3'd1 || bus.mdu_op == 3'd2) ? 5 : 10;
            else if (mcnt != 0 && !bus.req)
                mcnt <= mcnt - 1;
        end
    end
    assign bus.mdu_busy = late ? busy_d : (mcnt != 0);

    typedef struct {
        bit         rst, req, ev;
        logic [2:0] op;
        bit         d;
        bit         e_start;
        logic [2:0] e_op;
        bit         e_stall, e_busy, e_mis;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic add(input bit rst, rq, ev, input logic [2:0] op, input bit d,
                       input bit es, input logic [2:0] eo, input bit est, eb);
        vec_t v;
        v.rst = rst; v.req = rq; v.ev = ev; v.op = op; v.d = d;
        v.e_start = es; v.e_op = eo; v.e_stall = est; v.e_busy = eb; v.e_mis = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int row, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input bit rst, rq, ev, input logic [2:0] op, input bit d);
        reset = rst; bus.req = rq; bus.e_valid = ev; bus.e_op = op; bus.d_hilo_use = d;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v, e;
        late = 1'b0;
        reset = 1'b1; bus.req = 1'b0; bus.e_valid = 1'b0; bus.e_op = 3'd0; bus.d_hilo_use = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        add(1,0,0,0,0, 0,0,0,0);
        // MULT at cycle 0: start once, busy cycles 1-5, idle at 6; op while RUN ignored
        add(0,0,1,1,0, 1,1,0,0);
        add(0,0,1,1,0, 0,0,0,1);
        repeat (4) add(0,0,0,0,0, 0,0,0,1);
        add(0,0,0,0,0, 0,0,0,0);
        // DIVU with mflo in D: stall cycles 0-10, released at 11
        add(0,0,1,4,1, 1,4,1,0);
        repeat (10) add(0,0,0,0,1, 0,0,1,1);
        add(0,0,0,0,1, 0,0,0,0);
        // MULT with req in cycles 2-3: busy 1-7, no re-start
        add(0,0,1,1,0, 1,1,0,0);
        add(0,0,0,0,0, 0,0,0,1);
        repeat (2) add(0,1,1,1,0, 0,0,0,1);
        repeat (4) add(0,0,0,0,0, 0,0,0,1);
        add(0,0,0,0,0, 0,0,0,0);
        // req blocks DIV issue in IDLE (no stall either), issue the next cycle
        add(0,1,1,3,1, 0,0,0,0);
        add(0,0,1,3,1, 1,3,1,0);
        repeat (10) add(0,0,0,0,0, 0,0,0,1);
        add(0,0,0,0,0, 0,0,0,0);
        // MTHI/MTLO issue without start; reserved op and invalid E are no-ops
        add(0,0,1,5,0, 0,5,0,0);
        add(0,0,1,6,0, 0,6,0,0);
        add(0,0,1,7,0, 0,0,0,0);
        add(0,0,0,1,1, 0,0,0,0);
        // DIV then reset at cycle 4: outputs gated, idle at cycle 5
        add(0,0,1,3,0, 1,3,0,0);
        repeat (3) add(0,0,0,0,0, 0,0,0,1);
        add(1,0,1,1,1, 0,0,0,1);
        add(0,0,0,0,0, 0,0,0,0);
        // MULTU uses the multiply latency
        add(0,0,1,2,0, 1,2,0,0);
        repeat (5) add(0,0,0,0,0, 0,0,0,1);
        add(0,0,0,0,0, 0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            exp_q.push_back(v);
            drive(v.rst, v.req, v.ev, v.op, v.d);
            e = exp_q.pop_front();
            chk("mdu_start", i, {3'b0, bus.mdu_start}, {3'b0, e.e_start});
            chk("mdu_op",    i, {1'b0, bus.mdu_op},    {1'b0, e.e_op});
            chk("stall_d",   i, {3'b0, bus.stall_d},   {3'b0, e.e_stall});
            chk("ctrl_busy", i, {3'b0, bus.ctrl_busy}, {3'b0, e.e_busy});
            chk("mismatch",  i, {3'b0, bus.mismatch},  {3'b0, e.e_mis});
            advance();
        end

        // Late model busy: mismatch must rise and stick until reset
        late = 1'b1;
        drive(0,0,1,1,0);
        chk("mis_pre", 0, {3'b0, bus.mismatch}, 4'd0);
        advance();
        for (int c = 1; c <= 9; c++) begin
            drive(0,0,0,0,0);
            if (c == 3 || c == 9)
                chk("mis_sticky", c, {3'b0, bus.mismatch}, 4'd1);
            advance();
        end
        drive(1,0,0,0,0);
        advance();
        late = 1'b0;
        drive(0,0,0,0,0);
        chk("mis_clear", 0, {3'b0, bus.mismatch}, 4'd0);
        advance();
        drive(0,0,0,0,0);
        chk("mis_stay0", 1, {3'b0, bus.mismatch}, 4'd0);
        advance();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
